pwm_generator_mc: RTL and testbench

PWM_GENERATOR_MC -- requirements
Module: pwm_generator_mc

---
 rtl/pwm_generator_mc.sv | 130 +++++++++++++
 tb/tb_pwm_generator_mc.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_generator_mc.sv
// Multi-channel PWM generator with a one-deep shadowed duty register per period.
// Optional build macro PWM_CENTER_ALIGN_EN selects an up/down (centre-aligned) step counter.
module pwm_generator_mc #(
    parameter int CHANNELS         = 2,
    parameter int PWM_BITS         = 6,
    parameter int CLKS_IN_PWM_STEP = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [CHANNELS*PWM_BITS-1:0] duty_in,
    input  logic                         duty_valid,
    output logic                         duty_ready,
    output logic                         symbol,
    output logic [CHANNELS-1:0]          pwm,
    output logic                         underrun
);

    localparam int PRESC_W = (CLKS_IN_PWM_STEP > 1) ? $clog2(CLKS_IN_PWM_STEP) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(CLKS_IN_PWM_STEP - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX   = '1;

    logic [PRESC_W-1:0]           presc;
    logic [PWM_BITS-1:0]          cnt;
    logic [CHANNELS*PWM_BITS-1:0] active_duty;
    logic [CHANNELS*PWM_BITS-1:0] shadow;
    logic                         full;

    logic                         step_tick;
    logic                         boundary;
    logic                         accept;
    logic                         full_nxt;
    logic [CHANNELS-1:0]          pwm_p0;

`ifdef PWM_CENTER_ALIGN_EN
    logic                         dir_down;
`endif

    // Stage p0: timebase decode and handshake bookkeeping
    always_comb begin
        step_tick = enable && (presc == PRESC_MAX);
`ifdef PWM_CENTER_ALIGN_EN
        boundary  = step_tick && dir_down && (cnt == '0);
`else
        boundary  = step_tick && (cnt == CNT_MAX);
`endif
        accept    = duty_valid && duty_ready;

        // Consume first, then capture, so a sample landing on an empty-shadow
        // boundary is held for the next period rather than bypassed.
        full_nxt = full;
        if (boundary) begin
            full_nxt = 1'b0;
        end
        if (accept) begin
            full_nxt = 1'b1;
        end
    end

    always_comb begin
        pwm_p0 = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            pwm_p0[k] = enable && (cnt < active_duty[k*PWM_BITS +: PWM_BITS]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            cnt   <= '0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_down <= 1'b0;
`endif
        end else if (!enable) begin
            presc <= '0;
            cnt   <= '0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_down <= 1'b0;
`endif
        end else begin
            presc <= step_tick ? '0 : presc + 1'b1;
            if (step_tick) begin
`ifdef PWM_CENTER_ALIGN_EN
                // Both ends are held for one extra step so the period is 2*2^PWM_BITS.
                if (!dir_down) begin
                    if (cnt == CNT_MAX) begin
                        dir_down <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    if (cnt == '0) begin
                        dir_down <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`else
                cnt <= cnt + 1'b1;
`endif
            end
        end
    end

    // Stage p1: registered duty state and outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_duty <= '0;
            shadow      <= '0;
            full        <= 1'b0;
            duty_ready  <= 1'b0;
            symbol      <= 1'b0;
            underrun    <= 1'b0;
            pwm         <= '0;
        end else begin
            full       <= full_nxt;
            duty_ready <= !full_nxt;
            if (accept) begin
                shadow <= duty_in;
            end
            if (boundary && full) begin
                active_duty <= shadow;
            end
            symbol   <= boundary;
            underrun <= boundary && !full;
            pwm      <= pwm_p0;
        end
    end

endmodule

// File: tb/tb_pwm_generator_mc.sv
// Scoreboard bench for pwm_generator_mc: per-period expectations are queued by the
// stimulus and checked by a monitor at every symbol strobe.
module tb_pwm_generator_mc;

    localparam int CHANNELS = 2;
    localparam int PWM_BITS = 6;
    localparam int CLKS     = 10;
`ifdef PWM_CENTER_ALIGN_EN
    localparam int MULT = 2;
`else
    localparam int MULT = 1;
`endif
    localparam int PER = MULT * CLKS * (1 << PWM_BITS);

    typedef struct {
        int hi0;
        int hi1;
        int und;
        int period;
    } exp_t;

    logic                         clk;
    logic                         rst;
    logic                         enable;
    logic [CHANNELS*PWM_BITS-1:0] duty_in;
    logic                         duty_valid;
    logic                         duty_ready;
    logic                         symbol;
    logic [CHANNELS-1:0]          pwm;
    logic                         underrun;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   widx    = 0;

    pwm_generator_mc #(
        .CHANNELS(CHANNELS),
        .PWM_BITS(PWM_BITS),
        .CLKS_IN_PWM_STEP(CLKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .duty_in(duty_in),
        .duty_valid(duty_valid),
        .duty_ready(duty_ready),
        .symbol(symbol),
        .pwm(pwm),
        .underrun(underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int h0, input int h1, input int u, input int p);
        exp_t e;
        e.hi0 = h0; e.hi1 = h1; e.und = u; e.period = p;
        q.push_back(e);
    endtask

    task automatic wait_symbol(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!symbol && n < 2*PER + 20);
        if (!symbol) begin
            n_tests++;
            n_fail++;
            $display("FAIL symbol_timeout: got no symbol within %0d cycles", n);
        end
    endtask

    task automatic send(input logic [CHANNELS*PWM_BITS-1:0] d);
        int n;
        n = 0;
        while (!duty_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_send", duty_ready, 1);
        duty_in    = d;
        duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
        chk("ready_drop_after_accept", duty_ready, 0);
    endtask

    // Monitor: accumulates high time over (previous symbol, this symbol]
    initial begin
        int   acc0, acc1, since;
        exp_t e;
        acc0 = 0; acc1 = 0; since = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                acc0 = 0; acc1 = 0; since = 0;
            end else begin
                acc0 += int'(pwm[0]);
                acc1 += int'(pwm[1]);
                since++;
                if (underrun && !symbol) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL underrun_without_symbol: got underrun=1 symbol=0 required symbol=1");
                end
                if (symbol) begin
                    widx++;
                    if (q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_symbol w%0d: got symbol with empty scoreboard", widx);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("w%0d_hi0", widx), acc0, e.hi0);
                        chk($sformatf("w%0d_hi1", widx), acc1, e.hi1);
                        chk($sformatf("w%0d_underrun", widx), int'(underrun), e.und);
                        if (e.period != 0) begin
                            chk($sformatf("w%0d_period", widx), since, e.period);
                        end
                    end
                    acc0 = 0; acc1 = 0; since = 0;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int act;
        rst        = 1'b0;
        enable     = 1'b0;
        duty_valid = 1'b0;
        duty_in    = '0;
        repeat (3) @(negedge clk);
        chk("reset_pwm", int'(pwm), 0);
        chk("reset_symbol", int'(symbol), 0);
        chk("reset_underrun", int'(underrun), 0);
        chk("reset_ready", int'(duty_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_release", int'(duty_ready), 1);

        // Duty 10/20 loaded before enable; first period still runs the reset duty.
        push(0, 0, 0, 0);
        push(100*MULT, 200*MULT, 1, PER);
        push(100*MULT, 200*MULT, 0, PER);
        push(0, 630*MULT, 1, PER);
        send({6'd20, 6'd10});
        repeat (5) @(negedge clk);
        enable = 1'b1;
        wait_symbol(n);
        chk("enable_to_first_symbol", n, PER);
        wait_symbol(n);
        chk("ready_held_after_underrun", int'(duty_ready), 1);
        repeat (50) @(negedge clk);
        send({6'd63, 6'd0});
        wait_symbol(n);
        wait_symbol(n);
        chk("ready_after_second_underrun", int'(duty_ready), 1);

        // Sample accepted exactly on a boundary with an empty shadow.
        push(0, 630*MULT, 1, PER);
        push(0, 630*MULT, 0, PER);
        push(50*MULT, 400*MULT, 1, PER);
        repeat (PER-1) @(negedge clk);
        duty_in    = {6'd40, 6'd5};
        duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
        chk("boundary_accept_underrun", int'(underrun), 1);
        chk("boundary_accept_symbol", int'(symbol), 1);
        chk("boundary_accept_ready", int'(duty_ready), 0);
        wait_symbol(n);
        wait_symbol(n);

        // Disabled: no outputs, then restart from step 0.
        enable = 1'b0;
        act = 0;
        repeat (PER + 60) begin
            @(negedge clk);
            act += int'(pwm != '0) + int'(symbol) + int'(underrun);
        end
        chk("disabled_activity", act, 0);
        push(50*MULT, 400*MULT, 1, 0);
        enable = 1'b1;
        wait_symbol(n);
        chk("reenable_to_symbol", n, PER);

        // Reset mid-period with a full shadow.
        send({6'd30, 6'd30});
        repeat (200) @(negedge clk);
        chk("pwm_before_reset", int'(pwm), 2);
        #2 rst = 1'b0;
        #1;
        chk("pwm_in_reset", int'(pwm), 0);
        chk("ready_in_reset", int'(duty_ready), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_mid_reset", int'(duty_ready), 1);
        push(0, 0, 1, 0);
        push(0, 0, 1, PER);
        wait_symbol(n);
        wait_symbol(n);
        chk("scoreboard_left", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
